fetch_unit: RTL and testbench

//   Instruction-fetch reader sitting between the PC register and instruction memory.
//   - On a control-unit start pulse: captures the PC value, issues a memory read and waits for ack.
//   - On ack: latches the returned word into the instruction register.
//   - Then pulses done plus a one-cycle increment request back to the PC register.
//   - Word-addressed: PC advances by 1 per fetch.

---
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch reader: captures the PC on start, reads instruction memory and loads the IR.
// Optional macro FETCH_TIMEOUT_EN adds a WAIT-cycle timeout that aborts into the ERR state.
module fetch_unit #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic [DATA_W-1:0] ir_out,
    output logic              pc_inc,
    output logic              done,
    output logic              busy,
    output logic              error
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
`ifdef FETCH_TIMEOUT_EN
        ,
        S_ERR  = 2'd3
`endif
    } state_t;

    state_t state;

    // A timeout shorter than two cycles would abort before memory could ever answer.
    if (TIMEOUT < 2) begin : g_timeout_too_small
        $error("fetch_unit: TIMEOUT must be at least 2");
    end

`ifdef FETCH_TIMEOUT_EN
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
    logic [15:0] wait_cnt;
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state    <= S_IDLE;
            mem_addr <= '0;
            ir_out   <= '0;
            mem_rd   <= 1'b0;
            pc_inc   <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            error    <= 1'b0;
            wait_cnt <= '0;
`endif
        end else begin
            done   <= 1'b0;
            pc_inc <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mem_addr <= pc_in;
                        mem_rd   <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_WAIT;
`ifdef FETCH_TIMEOUT_EN
                        error    <= 1'b0;
                        wait_cnt <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    // An ack on the timeout edge still completes the fetch.
                    if (mem_ack) begin
                        ir_out <= mem_data_in;
                        mem_rd <= 1'b0;
                        done   <= 1'b1;
                        pc_inc <= 1'b1;
                        state  <= S_DONE;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (wait_cnt == WAIT_LAST) begin
                        mem_rd <= 1'b0;
                        error  <= 1'b1;
                        state  <= S_ERR;
                    end else if (wait_cnt != 16'hFFFF) begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
`endif
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
`ifdef FETCH_TIMEOUT_EN
                S_ERR: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
`endif
                default: begin
                    mem_rd <= 1'b0;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; checks every output after each clock edge.
// The timeout scenario is exercised only when FETCH_TIMEOUT_EN is defined.
module tb_fetch_unit;

`ifdef FETCH_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
    localparam logic EXP_ERR_ON = 1'b1;
`else
    localparam int TB_TIMEOUT = 16;
    localparam logic EXP_ERR_ON = 1'b0;
`endif
    // Long-wait fetch is shortened so it stays inside the timeout window when enabled.
    localparam int T3_WAITS = (TB_TIMEOUT > 6) ? 5 : TB_TIMEOUT - 2;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        start;
    logic [31:0] pc_in;
    logic        mem_ack;
    logic [31:0] mem_data_in;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] ir_out;
    logic        pc_inc;
    logic        done;
    logic        busy;
    logic        error;

    int total = 0;
    int bad   = 0;

    fetch_unit #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .start      (start),
        .pc_in      (pc_in),
        .mem_ack    (mem_ack),
        .mem_data_in(mem_data_in),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .ir_out     (ir_out),
        .pc_inc     (pc_inc),
        .done       (done),
        .busy       (busy),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic [31:0] pc,
                                 input logic ack, input logic [31:0] data);
        start       = st;
        pc_in       = pc;
        mem_ack     = ack;
        mem_data_in = data;
    endtask

    task automatic cmp(input string tag, input string sig,
                       input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, sig, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] e_addr, input logic e_rd,
                               input logic [31:0] e_ir, input logic e_inc, input logic e_done,
                               input logic e_busy, input logic e_err);
        cmp(tag, "mem_addr", 64'(mem_addr), 64'(e_addr));
        cmp(tag, "mem_rd",   64'(mem_rd),   64'(e_rd));
        cmp(tag, "ir_out",   64'(ir_out),   64'(e_ir));
        cmp(tag, "pc_inc",   64'(pc_inc),   64'(e_inc));
        cmp(tag, "done",     64'(done),     64'(e_done));
        cmp(tag, "busy",     64'(busy),     64'(e_busy));
        cmp(tag, "error",    64'(error),    64'(e_err));
    endtask

    initial begin
        $display("[TB] fetch_unit bench, TIMEOUT=%0d", TB_TIMEOUT);
        clr_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        tick();
        checkOutput("reset", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        clr_n = 1'b1;
        tick();
        checkOutput("idle_after_reset", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Zero-wait fetch
        applyStimulus(1'b1, 32'h10, 1'b0, 32'h0);
        tick();
        checkOutput("t2_wait", 32'h10, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h10, 1'b1, 32'hDEADBEEF);
        tick();
        checkOutput("t2_done", 32'h10, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h10, 1'b0, 32'h0);
        tick();
        checkOutput("t2_idle", 32'h10, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0);

        // Multi-cycle memory latency
        applyStimulus(1'b1, 32'h20, 1'b0, 32'h0);
        tick();
        checkOutput("t3_wait0", 32'h20, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h20, 1'b0, 32'h0);
        for (int i = 0; i < T3_WAITS; i++) begin
            tick();
            checkOutput("t3_waitn", 32'h20, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 32'h20, 1'b1, 32'h12345678);
        tick();
        checkOutput("t3_done", 32'h20, 1'b0, 32'h12345678, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h20, 1'b0, 32'h0);
        tick();
        checkOutput("t3_idle", 32'h20, 1'b0, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0);

        // Start while busy, pc_in moving during WAIT, ack while idle
        applyStimulus(1'b1, 32'h20, 1'b0, 32'h0);
        tick();
        checkOutput("t4_wait0", 32'h20, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h99, 1'b0, 32'h0);
        tick();
        checkOutput("t4_wait_start", 32'h20, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h99, 1'b1, 32'hCAFEF00D);
        tick();
        checkOutput("t4_done", 32'h20, 1'b0, 32'hCAFEF00D, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h99, 1'b0, 32'h0);
        tick();
        checkOutput("t4_done_start", 32'h20, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h99, 1'b1, 32'hBAD0BAD0);
        tick();
        checkOutput("t4_idle_ack", 32'h20, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h99, 1'b0, 32'h0);
        tick();
        checkOutput("t4_idle", 32'h20, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of WAIT
        applyStimulus(1'b1, 32'h40, 1'b0, 32'h0);
        tick();
        checkOutput("t5_wait", 32'h40, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h40, 1'b0, 32'h0);
        #2;
        clr_n = 1'b0;
        #1;
        checkOutput("t5_async", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h40, 1'b1, 32'h77777777);
        tick();
        checkOutput("t5_held", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        clr_n = 1'b1;
        applyStimulus(1'b1, 32'h50, 1'b0, 32'h0);
        tick();
        checkOutput("t5_restart", 32'h50, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h50, 1'b1, 32'h00000001);
        tick();
        checkOutput("t5_done", 32'h50, 1'b0, 32'h00000001, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h50, 1'b0, 32'h0);
        tick();
        checkOutput("t5_idle", 32'h50, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef FETCH_TIMEOUT_EN
        // Timeout without ack, then ack exactly on the timeout edge
        applyStimulus(1'b1, 32'h60, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 32'h60, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t6_wait", 32'h60, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        tick();
        checkOutput("t6_err", 32'h60, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b1, EXP_ERR_ON);
        tick();
        checkOutput("t6_sticky", 32'h60, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0, EXP_ERR_ON);
        applyStimulus(1'b1, 32'h70, 1'b0, 32'h0);
        tick();
        checkOutput("t6_clear", 32'h70, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h70, 1'b0, 32'h0);
        tick();
        tick();
        tick();
        applyStimulus(1'b0, 32'h70, 1'b1, 32'hA5A5A5A5);
        tick();
        checkOutput("t6_ack_wins", 32'h70, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h70, 1'b0, 32'h0);
        tick();
        checkOutput("t6_idle", 32'h70, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 1'b0);
`else
        cmp("no_timeout", "error", 64'(error), 64'(EXP_ERR_ON));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
